// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage.
//  - RF_ADDR_W : register-file address width
//  - F3_*      : load funct3 encodings understood by load_align
//  - wb_src_e  : which source drives the register-file write port in a cycle
package wb_stage_pkg;

  localparam int RF_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LD   = 2'd1,
    SRC_SKID = 2'd2,
    SRC_EX   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational load-data formatter.
//  funct3  in  3   load type (LB/LH/LW/LBU/LHU; other codes yield 0)
//  addr_lo in  2   effective address bits [1:0]
//  rdata   in  32  raw aligned memory word
//  data32  out 32  byte/halfword selected and sign/zero-extended
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data32
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    // Halfword lane comes from addr_lo[1] only; a misaligned addr_lo[0] is ignored.
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data32 = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data32 = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data32 = rdata;
      F3_LBU:  data32 = {24'h0, byte_sel};
      F3_LHU:  data32 = {16'h0, half_sel};
      default: data32 = 32'h0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: RV32 writeback stage driving the register-file write port.
//  clk, rst_n                    clock, async active-low reset
//  ex_valid/ex_ready             EX result handshake
//  ex_wen, ex_rd, ex_data        EX result payload
//  ld_valid, ld_rd, ld_funct3,
//  ld_addr_lo, ld_rdata          load return (never back-pressured)
//  WB_wen, WB_wraddr, WB_wrdata  registered register-file write port
//  WB_pend_valid, WB_pend_rd     skid entry visible to decode for interlock
//  WB_instret                    retired-instruction counter
//
// Handshake: an EX result transfers on a cycle where ex_valid and ex_ready are
// both high. ex_ready depends only on stage state (skid empty), never on
// ex_valid. A load must be written the cycle it arrives, so when an EX write
// collides with it the EX write parks in the 1-entry skid and ex_ready drops
// until that entry has been written.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_wen,
  input  logic [RF_ADDR_W-1:0] ex_rd,
  input  logic [31:0]          ex_data,
  input  logic                 ld_valid,
  input  logic [RF_ADDR_W-1:0] ld_rd,
  input  logic [2:0]           ld_funct3,
  input  logic [1:0]           ld_addr_lo,
  input  logic [31:0]          ld_rdata,
  output logic                 WB_wen,
  output logic [RF_ADDR_W-1:0] WB_wraddr,
  output logic [31:0]          WB_wrdata,
  output logic                 WB_pend_valid,
  output logic [RF_ADDR_W-1:0] WB_pend_rd,
  output logic [CNT_W-1:0]     WB_instret
);

  logic                 skid_valid_q, skid_valid_d;
  logic [RF_ADDR_W-1:0] skid_rd_q, skid_rd_d;
  logic [31:0]          skid_data_q, skid_data_d;
  logic                 wen_q, wen_d;
  logic [RF_ADDR_W-1:0] wraddr_q, wraddr_d;
  logic [31:0]          wrdata_q, wrdata_d;
  logic [CNT_W-1:0]     instret_q, instret_d;

  logic        ex_acc;
  logic        ex_take;
  logic [31:0] ld_data;
  wb_src_e     src;

  load_align u_load_align (
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .rdata   (ld_rdata),
    .data32  (ld_data)
  );

  assign ex_ready = ~skid_valid_q;
  assign ex_acc   = ex_valid & ex_ready;
  // Only accepted EX results that write rd compete for the port.
  assign ex_take  = ex_acc & ex_wen;

  always_comb begin
    src          = SRC_NONE;
    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    wraddr_d     = wraddr_q;
    wrdata_d     = wrdata_q;

    if (ld_valid)          src = SRC_LD;
    else if (skid_valid_q) src = SRC_SKID;
    else if (ex_take)      src = SRC_EX;

    case (src)
      SRC_LD: begin
        wraddr_d = ld_rd;
        wrdata_d = ld_data;
      end
      SRC_SKID: begin
        wraddr_d     = skid_rd_q;
        wrdata_d     = skid_data_q;
        skid_valid_d = 1'b0;
      end
      SRC_EX: begin
        wraddr_d = ex_rd;
        wrdata_d = ex_data;
      end
      default: ;
    endcase

    // Fill cannot coincide with a drain: ex_take implies the skid was empty.
    if (ld_valid && ex_take) begin
      skid_valid_d = 1'b1;
      skid_rd_d    = ex_rd;
      skid_data_d  = ex_data;
    end

    // x0 writes still move the address/data registers but never enable the port.
    wen_d     = (src != SRC_NONE) && (wraddr_d != '0);
    instret_d = instret_q + CNT_W'(ld_valid) + CNT_W'(ex_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_rd_q    <= '0;
      skid_data_q  <= '0;
      wen_q        <= 1'b0;
      wraddr_q     <= '0;
      wrdata_q     <= '0;
      instret_q    <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_rd_q    <= skid_rd_d;
      skid_data_q  <= skid_data_d;
      wen_q        <= wen_d;
      wraddr_q     <= wraddr_d;
      wrdata_q     <= wrdata_d;
      instret_q    <= instret_d;
    end
  end

  assign WB_wen        = wen_q;
  assign WB_wraddr     = wraddr_q;
  assign WB_wrdata     = wrdata_q;
  assign WB_pend_valid = skid_valid_q;
  assign WB_pend_rd    = skid_rd_q;
  assign WB_instret    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases with literal expectations, then random
// traffic checked every cycle against a queue-based model of the stage.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_wen;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_rdata;

  logic        ex_ready, WB_wen, WB_pend_valid;
  logic [4:0]  WB_wraddr, WB_pend_rd;
  logic [31:0] WB_wrdata;
  logic [63:0] WB_instret;

  logic        s_ex_ready, s_wen, s_pend_valid;
  logic [4:0]  s_wraddr, s_pend_rd;
  logic [31:0] s_wrdata;
  logic [3:0]  s_instret;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 0;

  // Model state: what the outputs must be after the most recent clock edge.
  logic [36:0] exp_q[$];   // pending EX writes {rd, data}, oldest first
  logic        m_wen = 0;
  logic [4:0]  m_addr = 0;
  logic [31:0] m_data = 0;
  logic [63:0] m_cnt = 0;

  wb_stage #(.CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .ld_rdata(ld_rdata),
    .WB_wen(WB_wen), .WB_wraddr(WB_wraddr), .WB_wrdata(WB_wrdata),
    .WB_pend_valid(WB_pend_valid), .WB_pend_rd(WB_pend_rd), .WB_instret(WB_instret)
  );

  // Narrow-counter copy so that wraparound happens naturally in a short run.
  wb_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(s_ex_ready), .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .ld_rdata(ld_rdata),
    .WB_wen(s_wen), .WB_wraddr(s_wraddr), .WB_wrdata(s_wrdata),
    .WB_pend_valid(s_pend_valid), .WB_pend_rd(s_pend_rd), .WB_instret(s_instret)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [2:0] f, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_wen  = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_cnt  = '0;
    end else begin
      bit          acc, have;
      logic [4:0]  a;
      logic [31:0] d;
      logic [36:0] e;
      acc  = ex_valid && (exp_q.size() == 0);
      have = 0;
      a    = '0;
      d    = '0;
      if (ld_valid) begin
        have = 1; a = ld_rd; d = fmt_load(ld_funct3, ld_addr_lo, ld_rdata);
        if (acc && ex_wen) exp_q.push_back({ex_rd, ex_data});
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        have = 1; a = e[36:32]; d = e[31:0];
      end else if (acc && ex_wen) begin
        have = 1; a = ex_rd; d = ex_data;
      end
      m_wen = have && (a != 0);
      if (have) begin
        m_addr = a;
        m_data = d;
      end
      m_cnt = m_cnt + 64'(ld_valid) + 64'(acc);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      logic [36:0] h;
      chk("wen",        64'(WB_wen),        64'(m_wen));
      chk("wraddr",     64'(WB_wraddr),     64'(m_addr));
      chk("wrdata",     64'(WB_wrdata),     64'(m_data));
      chk("ex_ready",   64'(ex_ready),      64'(exp_q.size() == 0));
      chk("pend_valid", 64'(WB_pend_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        chk("pend_rd", 64'(WB_pend_rd), 64'(h[36:32]));
      end
      chk("instret",    WB_instret,         m_cnt);
      chk("instret_w4", 64'(s_instret),     64'(m_cnt[3:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    ex_valid = 0; ex_wen = 0; ex_rd = '0; ex_data = '0;
    ld_valid = 0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0; ld_rdata = '0;
  endtask

  task automatic set_ex(input logic wen, input logic [4:0] rd, input logic [31:0] data);
    ex_valid = 1; ex_wen = wen; ex_rd = rd; ex_data = data;
  endtask

  task automatic set_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    ld_valid = 1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = a; ld_rdata = w;
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string name, input logic wen, input logic [4:0] a, input logic [31:0] d);
    chk({name, "_wen"},  64'(WB_wen),    64'(wen));
    chk({name, "_addr"}, 64'(WB_wraddr), 64'(a));
    chk({name, "_data"}, 64'(WB_wrdata), 64'(d));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    chk_on = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", 64'(WB_wen), 64'd0);
    chk("rst_ready", 64'(ex_ready), 64'd1);
    chk("rst_instret", WB_instret, 64'd0);
    chk("rst_pend_rd", 64'(WB_pend_rd), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Single EX write.
    set_ex(1, 5'd5, 32'h1234); step(); set_idle();
    chk_wr("t1", 1, 5'd5, 32'h1234);
    chk("t1_instret", WB_instret, 64'd1);

    // Load formatting.
    set_ld(5'd3, 3'b000, 2'd2, 32'h0080_0000); step();
    chk_wr("lb", 1, 5'd3, 32'hFFFF_FF80);
    set_ld(5'd3, 3'b100, 2'd2, 32'h0080_0000); step();
    chk_wr("lbu", 1, 5'd3, 32'h0000_0080);
    set_ld(5'd3, 3'b001, 2'd2, 32'h8001_0000); step(); set_idle();
    chk_wr("lh", 1, 5'd3, 32'hFFFF_8001);
    chk("t2_instret", WB_instret, 64'd4);

    // Collision: load wins, EX parks in the skid.
    set_ld(5'd1, 3'b010, 2'd0, 32'hAAAA_0000); set_ex(1, 5'd2, 32'h55); step(); set_idle();
    chk_wr("col1", 1, 5'd1, 32'hAAAA_0000);
    chk("col1_pend", 64'(WB_pend_valid), 64'd1);
    chk("col1_pend_rd", 64'(WB_pend_rd), 64'd2);
    chk("col1_ready", 64'(ex_ready), 64'd0);
    chk("col1_instret", WB_instret, 64'd6);
    step();
    chk_wr("col2", 1, 5'd2, 32'h55);
    step();
    chk("col3_ready", 64'(ex_ready), 64'd1);

    // EX without rd write colliding with a load; then an x0 write.
    set_ld(5'd7, 3'b010, 2'd0, 32'h11); set_ex(0, 5'd9, 32'h77); step(); set_idle();
    chk_wr("nowen", 1, 5'd7, 32'h11);
    chk("nowen_pend", 64'(WB_pend_valid), 64'd0);
    chk("nowen_ready", 64'(ex_ready), 64'd1);
    chk("nowen_instret", WB_instret, 64'd8);
    set_ex(1, 5'd0, 32'h99); step(); set_idle();
    chk_wr("x0", 0, 5'd0, 32'h99);
    chk("x0_instret", WB_instret, 64'd9);

    // Skid full while loads keep arriving: loads first, skid entry last.
    set_ld(5'd10, 3'b010, 2'd0, 32'hA); set_ex(1, 5'd11, 32'hB); step();
    chk_wr("hold0", 1, 5'd10, 32'hA);
    set_ex(1, 5'd20, 32'hEE);
    for (int i = 0; i < 3; i++) begin
      chk("hold_ready", 64'(ex_ready), 64'd0);
      set_ld(5'(12 + i), 3'b010, 2'd0, 32'(12 + i)); step();
      chk_wr("hold_ld", 1, 5'(12 + i), 32'(12 + i));
    end
    chk("hold_ready_end", 64'(ex_ready), 64'd0);
    set_idle(); step();
    chk_wr("hold_skid", 1, 5'd11, 32'hB);
    chk("hold_instret", WB_instret, 64'd14);

    // Reset while the skid holds an entry.
    set_ld(5'd4, 3'b010, 2'd0, 32'h4); set_ex(1, 5'd6, 32'h6); step();
    chk("pre_rst_pend", 64'(WB_pend_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_wr("mid_rst", 0, 5'd0, 32'h0);
    chk("mid_rst_pend", 64'(WB_pend_valid), 64'd0);
    chk("mid_rst_instret", WB_instret, 64'd0);
    chk("mid_rst_ready", 64'(ex_ready), 64'd1);
    step(); set_idle();
    @(negedge clk); #1 rst_n = 1'b1;

    // Random traffic; the per-cycle compare carries the checking.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      set_idle();
      if ($urandom_range(0, 9) < 7) set_ex($urandom_range(0, 4) != 0, 5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 9) < 5)
        set_ld(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 15) == 0) begin
        if (ex_rd != 0) ex_rd = 5'd0;
      end
    end
    @(negedge clk); #1 set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
